// File: rtl/lsu_mem_if.sv
// Load/store unit between the RV32I datapath and a word-wide request/grant/response
// data bus; stalls the core while an access is outstanding and aborts on timeout.
//
// state | meaning
// IDLE  | no access in flight; launches a legal access or flags an illegal one
// REQ   | mem_req high, bus outputs held until mem_gnt
// WAIT  | read granted, waiting for mem_rvalid
// DONE  | one-cycle commit slot for the core; ReadData/BusErr valid
module lsu_mem_if #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        MisalignErr,
   output logic        BusErr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [3:0]       be_q, be_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [2:0]       f3_q, f3_d;
   logic [1:0]       off_q, off_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             berr_q, berr_d;

   logic        access, legal, launch, tmo;
   logic [3:0]  be_new;
   logic [31:0] wdata_new, load_val;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign access = MemRead | MemWrite;
   assign launch = (state_q == S_IDLE) & access & legal;

   // Unsigned sizes exist only for loads; 011/11x are undefined encodings.
   always_comb begin
      legal = 1'b0;
      case (funct3)
         3'b000:  legal = 1'b1;
         3'b001:  legal = ~ALUResult[0];
         3'b010:  legal = (ALUResult[1:0] == 2'b00);
         3'b100:  legal = ~MemWrite;
         3'b101:  legal = ~MemWrite & ~ALUResult[0];
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      be_new    = 4'b1111;
      wdata_new = WriteData;
      case (funct3[1:0])
         2'b00: begin
            be_new    = 4'b0001 << ALUResult[1:0];
            wdata_new = {4{WriteData[7:0]}};
         end
         2'b01: begin
            be_new    = ALUResult[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{WriteData[15:0]}};
         end
         default: begin
            be_new    = 4'b1111;
            wdata_new = WriteData;
         end
      endcase
   end

   assign lane_b = mem_rdata[{off_q, 3'b000} +: 8];
   assign lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      load_val = mem_rdata;
      case (f3_q)
         3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_val = {24'd0, lane_b};
         3'b101:  load_val = {16'd0, lane_h};
         default: load_val = mem_rdata;
      endcase
   end

   assign tmo = ((state_q == S_REQ) | (state_q == S_WAIT)) &
                (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      off_d   = off_q;
      rdata_d = rdata_q;
      berr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (launch) begin
               state_d = S_REQ;
               cnt_d   = '0;
               we_d    = MemWrite;
               addr_d  = {ALUResult[31:2], 2'b00};
               be_d    = be_new;
               wdata_d = wdata_new;
               f3_d    = funct3;
               off_d   = ALUResult[1:0];
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (tmo) begin
               state_d = S_DONE;
               berr_d  = 1'b1;
               rdata_d = '0;
            end else if (mem_gnt) begin
               state_d = we_q ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (tmo) begin
               state_d = S_DONE;
               berr_d  = 1'b1;
               rdata_d = '0;
            end else if (mem_rvalid) begin
               state_d = S_DONE;
               rdata_d = load_val;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         rdata_q <= '0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         rdata_q <= rdata_d;
         berr_q  <= berr_d;
      end
   end

   assign Stall       = reset & (launch | (state_q == S_REQ) | (state_q == S_WAIT));
   assign MisalignErr = reset & (state_q == S_IDLE) & access & ~legal;
   assign ReadData    = MisalignErr ? 32'd0 : rdata_q;
   assign BusErr      = berr_q;
   assign mem_req     = (state_q == S_REQ) & ~tmo;
   assign mem_we      = we_q;
   assign mem_addr    = addr_q;
   assign mem_be      = be_q;
   assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: two instances (long and short timeout) share stimulus,
// each checked every cycle against a transaction-level model, plus literal spot checks.
module tb_lsu_mem_if;

   localparam int T0 = 64;
   localparam int T1 = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] ALUResult = '0, WriteData = '0;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   logic [31:0] s0_rd, s1_rd, s0_addr, s1_addr, s0_wd, s1_wd;
   logic        s0_stall, s1_stall, s0_mis, s1_mis, s0_berr, s1_berr;
   logic        s0_req, s1_req, s0_we, s1_we;
   logic [3:0]  s0_be, s1_be;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lsu_mem_if #(.TIMEOUT(T0), .CNT_W(10)) u0 (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
      .ReadData(s0_rd), .Stall(s0_stall), .MisalignErr(s0_mis), .BusErr(s0_berr),
      .mem_req(s0_req), .mem_we(s0_we), .mem_addr(s0_addr), .mem_be(s0_be),
      .mem_wdata(s0_wd), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

   lsu_mem_if #(.TIMEOUT(T1), .CNT_W(10)) u1 (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
      .ReadData(s1_rd), .Stall(s1_stall), .MisalignErr(s1_mis), .BusErr(s1_berr),
      .mem_req(s1_req), .mem_we(s1_we), .mem_addr(s1_addr), .mem_be(s1_be),
      .mem_wdata(s1_wd), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

   // Model of one outstanding access: launched / granted / finished flags and its age.
   typedef struct packed {
      logic        active;
      logic        store;
      logic        granted;
      logic        fin;
      logic        berr;
      logic [10:0] age;
      logic [31:0] rd;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [2:0]  f3;
      logic [1:0]  off;
   } acc_t;

   acc_t m0 = '0;
   acc_t m1 = '0;

   function automatic int m_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a, input bit st);
      int sz;
      sz = m_size(f3);
      if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
      if (st && f3[2]) return 1'b0;
      return (int'(a[2:0]) % sz) == 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int sz;
      sz = m_size(f3);
      return 4'(((1 << sz) - 1) << a[1:0]);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      int sz;
      sz = m_size(f3);
      if (sz == 1) return 32'(wd[7:0]) * 32'h0101_0101;
      if (sz == 2) return 32'(wd[15:0]) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] rdata);
      int sz;
      logic [31:0] mask, v;
      sz   = m_size(f3);
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
      v    = (rdata >> (8 * int'(off))) & mask;
      if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
      return v;
   endfunction

   function automatic acc_t mstep(input acc_t m, input int tmo);
      acc_t n;
      n = m;
      n.berr = 1'b0;
      if (m.fin) begin
         n.fin = 1'b0;
         return n;
      end
      if (!m.active) begin
         if ((MemRead || MemWrite) && m_legal(funct3, ALUResult, MemWrite)) begin
            n.active  = 1'b1;
            n.store   = MemWrite;
            n.granted = 1'b0;
            n.age     = '0;
            n.addr    = ALUResult & 32'hFFFF_FFFC;
            n.be      = m_be(funct3, ALUResult);
            n.wd      = m_wdata(funct3, WriteData);
            n.f3      = funct3;
            n.off     = ALUResult[1:0];
         end
         return n;
      end
      if (int'(m.age) == tmo - 1) begin
         n.active = 1'b0;
         n.fin    = 1'b1;
         n.berr   = 1'b1;
         n.rd     = '0;
      end else if (!m.granted) begin
         if (mem_gnt) begin
            n.granted = 1'b1;
            if (m.store) begin
               n.active = 1'b0;
               n.fin    = 1'b1;
            end
         end
      end else if (mem_rvalid) begin
         n.rd     = m_load(m.f3, m.off, mem_rdata);
         n.active = 1'b0;
         n.fin    = 1'b1;
      end
      n.age = m.age + 11'd1;
      return n;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m0 <= '0;
         m1 <= '0;
      end else begin
         m0 <= mstep(m0, T0);
         m1 <= mstep(m1, T1);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp(input string tg, input acc_t m, input int tmo,
                      input logic st, input logic mis, input logic req, input logic be_o,
                      input logic [31:0] rdv, input logic we, input logic [31:0] ad,
                      input logic [3:0] be, input logic [31:0] wd);
      bit idle_req, lg, e_stall, e_mis, e_req;
      idle_req = !m.active && !m.fin && (MemRead || MemWrite);
      lg       = m_legal(funct3, ALUResult, MemWrite);
      e_stall  = reset && (m.active || (idle_req && lg));
      e_mis    = reset && idle_req && !lg;
      e_req    = m.active && !m.granted && (int'(m.age) != tmo - 1);
      chk({tg, " Stall"}, 32'(st), 32'(e_stall));
      chk({tg, " MisalignErr"}, 32'(mis), 32'(e_mis));
      chk({tg, " mem_req"}, 32'(req), 32'(e_req));
      chk({tg, " BusErr"}, 32'(be_o), 32'(m.fin && m.berr));
      chk({tg, " ReadData"}, rdv, e_mis ? 32'd0 : m.rd);
      if (e_req) begin
         chk({tg, " mem_we"}, 32'(we), 32'(m.store));
         chk({tg, " mem_addr"}, ad, m.addr);
         chk({tg, " mem_be"}, 32'(be), 32'(m.be));
         if (m.store) chk({tg, " mem_wdata"}, wd, m.wd);
      end
   endtask

   always @(negedge clk) begin
      cmp("u0", m0, T0, s0_stall, s0_mis, s0_req, s0_berr, s0_rd, s0_we, s0_addr, s0_be, s0_wd);
      cmp("u1", m1, T1, s1_stall, s1_mis, s1_req, s1_berr, s1_rd, s1_we, s1_addr, s1_be, s1_wd);
   end

   // Inputs change 1 time unit after the rising edge; spot checks follow 2 units later.
   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic g, input logic rv);
      @(posedge clk);
      #1;
      MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = a; WriteData = wd;
      mem_gnt = g; mem_rvalid = rv;
      #2;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      MemRead = 1'b0; MemWrite = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] ad, output logic [3:0] be,
                           output logic [31:0] wdo, output int stalls);
      stalls = 0;
      drive(1'b0, 1'b1, f3, a, wd, 1'b0, 1'b0);
      stalls += int'(s0_stall);
      drive(1'b0, 1'b1, f3, a, wd, 1'b1, 1'b0);
      stalls += int'(s0_stall);
      ad = s0_addr; be = s0_be; wdo = s0_wd;
      drive(1'b0, 1'b1, f3, a, wd, 1'b0, 1'b0);
      stalls += int'(s0_stall);
      idle();
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata,
                          output logic [31:0] r0, output logic [31:0] r1);
      mem_rdata = rdata;
      drive(1'b1, 1'b0, f3, a, 32'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, f3, a, 32'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, f3, a, 32'd0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, f3, a, 32'd0, 1'b0, 1'b0);
      r0 = s0_rd; r1 = s1_rd;
      idle();
   endtask

   typedef struct packed {
      logic [2:0]  f3;
      logic [31:0] a;
      logic        wr;
   } bad_t;

   initial begin
      logic [31:0] ad, wdo, r0, r1;
      logic [3:0]  be;
      int          stalls, reqs, berrs, berr_at;
      logic [31:0] rd_at;
      bad_t        bad_tab [4];

      bad_tab[0] = '{f3: 3'b010, a: 32'h102, wr: 1'b0};
      bad_tab[1] = '{f3: 3'b001, a: 32'h101, wr: 1'b0};
      bad_tab[2] = '{f3: 3'b100, a: 32'h200, wr: 1'b1};
      bad_tab[3] = '{f3: 3'b011, a: 32'h100, wr: 1'b0};

      // Held in reset with an access requested: nothing may react.
      drive(1'b1, 1'b0, 3'b010, 32'h103, 32'd0, 1'b1, 1'b1);
      chk("reset Stall", 32'(s0_stall), 32'd0);
      chk("reset MisalignErr", 32'(s0_mis), 32'd0);
      chk("reset mem_req", 32'(s0_req), 32'd0);
      chk("reset mem_addr", s0_addr, 32'd0);
      chk("reset ReadData", s0_rd, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle();

      do_store(3'b010, 32'h100, 32'hDEADBEEF, ad, be, wdo, stalls);
      chk("SW addr", ad, 32'h100);
      chk("SW be", 32'(be), 32'hF);
      chk("SW wdata", wdo, 32'hDEADBEEF);
      chk("SW stall cycles", 32'(stalls), 32'd2);

      do_store(3'b000, 32'h201, 32'h0000005A, ad, be, wdo, stalls);
      chk("SB addr", ad, 32'h200);
      chk("SB be", 32'(be), 32'h2);
      chk("SB wdata", wdo, 32'h5A5A5A5A);

      do_store(3'b001, 32'h202, 32'h00001234, ad, be, wdo, stalls);
      chk("SH be", 32'(be), 32'hC);
      chk("SH wdata", wdo, 32'h12341234);

      do_load(3'b000, 32'h103, 32'h80FF0102, r0, r1);
      chk("LB data", r0, 32'hFFFFFF80);
      do_load(3'b100, 32'h103, 32'h80FF0102, r0, r1);
      chk("LBU data", r0, 32'h00000080);
      do_load(3'b001, 32'h102, 32'h80FF0102, r0, r1);
      chk("LH data", r0, 32'hFFFF80FF);
      chk("LH data short", r1, 32'hFFFF80FF);

      for (int i = 0; i < 4; i++) begin
         drive(!bad_tab[i].wr, bad_tab[i].wr, bad_tab[i].f3, bad_tab[i].a, 32'h1, 1'b0, 1'b0);
         chk($sformatf("illegal%0d MisalignErr", i), 32'(s0_mis), 32'd1);
         chk($sformatf("illegal%0d Stall", i), 32'(s0_stall), 32'd0);
         chk($sformatf("illegal%0d ReadData", i), s0_rd, 32'd0);
         idle();
         chk($sformatf("illegal%0d mem_req after", i), 32'(s0_req), 32'd0);
      end

      // Grant withheld 5 cycles, rvalid 3 cycles after grant.
      mem_rdata = 32'h11223344;
      reqs = 0;
      drive(1'b1, 1'b0, 3'b010, 32'h204, 32'd0, 1'b0, 1'b0);
      stalls = int'(s0_stall);
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, 1'b0, 3'b010, 32'h204, 32'd0, i == 6, 1'b0);
         reqs += int'(s0_req);
         stalls += int'(s0_stall);
      end
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 1'b0, 3'b010, 32'h204, 32'd0, 1'b0, i == 3);
         stalls += int'(s0_stall);
         chk($sformatf("slow WAIT%0d mem_req", i), 32'(s0_req), 32'd0);
      end
      drive(1'b1, 1'b0, 3'b010, 32'h204, 32'd0, 1'b0, 1'b0);
      chk("slow req cycles", 32'(reqs), 32'd6);
      chk("slow stall cycles", 32'(stalls), 32'd10);
      chk("slow DONE Stall", 32'(s0_stall), 32'd0);
      chk("slow ReadData", s0_rd, 32'h11223344);
      idle();
      do_reset();

      // Timeout on the short instance; prior load leaves ReadData nonzero.
      do_load(3'b010, 32'h300, 32'hCAFEF00D, r0, r1);
      chk("pre-timeout ReadData", r1, 32'hCAFEF00D);
      reqs = 0; berrs = 0; berr_at = 0; rd_at = 32'hFFFFFFFF;
      drive(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         drive(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 1'b0, 1'b0);
         if (i <= 9) reqs += int'(s1_req);
         if (s1_berr) begin
            berrs++;
            if (berr_at == 0) begin
               berr_at = i;
               rd_at   = s1_rd;
            end
         end
      end
      chk("timeout BusErr cycle", 32'(berr_at), 32'd9);
      chk("timeout BusErr count", 32'(berrs), 32'd1);
      chk("timeout ReadData", rd_at, 32'd0);
      chk("timeout req cycles", 32'(reqs), 32'd7);
      idle();
      do_reset();

      // Reset pulled during WAIT, then a late rvalid.
      do_load(3'b010, 32'h400, 32'h0BADCAFE, r0, r1);
      mem_rdata = 32'h55AA55AA;
      drive(1'b1, 1'b0, 3'b010, 32'h404, 32'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 3'b010, 32'h404, 32'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 3'b010, 32'h404, 32'd0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      chk("midreset Stall", 32'(s0_stall), 32'd0);
      chk("midreset mem_addr", s0_addr, 32'd0);
      chk("midreset mem_be", 32'(s0_be), 32'd0);
      chk("midreset ReadData", s0_rd, 32'd0);
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b1);
      reset = 1'b1;
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("late rvalid ReadData", s0_rd, 32'd0);
      chk("late rvalid Stall", 32'(s0_stall), 32'd0);
      idle();
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
